// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Dual-mode VGA raster timing generator. Produces horizontal/vertical pixel
//   counters, sync pulses with per-mode polarity, display enable and
//   line/frame start strobes. The requested mode is sampled on the last
//   enabled pixel of a frame and takes effect at the following origin.
//
// Ports
//   clk_25mhz      in   pixel clock
//   reset          in   synchronous active-high reset (returns to mode 0, origin)
//   ce             in   pixel advance enable; all state holds while low
//   mode_sel       in   requested mode, sampled only at end of frame
//   mode           out  mode currently in effect
//   h_count        out  horizontal position
//   v_count        out  vertical position
//   hsync          out  horizontal sync, polarity per active mode
//   vsync          out  vertical sync, polarity per active mode
//   display_enable out  high inside the visible area
//   line_start     out  one enabled cycle at h_count==0
//   frame_start    out  one enabled cycle at the origin
module vga_timing_gen #(
  parameter int unsigned COUNT_W      = 10,
  parameter int unsigned M0_H_DISPLAY = 640,
  parameter int unsigned M0_H_FRONT   = 16,
  parameter int unsigned M0_H_SYNC    = 96,
  parameter int unsigned M0_H_BACK    = 48,
  parameter int unsigned M0_V_DISPLAY = 480,
  parameter int unsigned M0_V_FRONT   = 10,
  parameter int unsigned M0_V_SYNC    = 2,
  parameter int unsigned M0_V_BACK    = 33,
  parameter bit          M0_H_POL     = 1'b0,
  parameter bit          M0_V_POL     = 1'b0,
  parameter int unsigned M1_H_DISPLAY = 640,
  parameter int unsigned M1_H_FRONT   = 16,
  parameter int unsigned M1_H_SYNC    = 96,
  parameter int unsigned M1_H_BACK    = 48,
  parameter int unsigned M1_V_DISPLAY = 400,
  parameter int unsigned M1_V_FRONT   = 12,
  parameter int unsigned M1_V_SYNC    = 2,
  parameter int unsigned M1_V_BACK    = 35,
  parameter bit          M1_H_POL     = 1'b0,
  parameter bit          M1_V_POL     = 1'b1
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  input  logic               ce,
  input  logic               mode_sel,
  output logic               mode,
  output logic [COUNT_W-1:0] h_count,
  output logic [COUNT_W-1:0] v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               display_enable,
  output logic               line_start,
  output logic               frame_start
);

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } mode_e;

  // Per-mode thresholds, all precomputed so runtime logic is only compares.
  typedef struct packed {
    logic [COUNT_W-1:0] h_last;
    logic [COUNT_W-1:0] h_disp;
    logic [COUNT_W-1:0] h_ss;
    logic [COUNT_W-1:0] h_se;
    logic [COUNT_W-1:0] v_last;
    logic [COUNT_W-1:0] v_disp;
    logic [COUNT_W-1:0] v_ss;
    logic [COUNT_W-1:0] v_se;
    logic               h_pol;
    logic               v_pol;
  } timing_t;

  localparam timing_t T0 = '{
    h_last: COUNT_W'(M0_H_DISPLAY + M0_H_FRONT + M0_H_SYNC + M0_H_BACK - 1),
    h_disp: COUNT_W'(M0_H_DISPLAY),
    h_ss:   COUNT_W'(M0_H_DISPLAY + M0_H_FRONT),
    h_se:   COUNT_W'(M0_H_DISPLAY + M0_H_FRONT + M0_H_SYNC),
    v_last: COUNT_W'(M0_V_DISPLAY + M0_V_FRONT + M0_V_SYNC + M0_V_BACK - 1),
    v_disp: COUNT_W'(M0_V_DISPLAY),
    v_ss:   COUNT_W'(M0_V_DISPLAY + M0_V_FRONT),
    v_se:   COUNT_W'(M0_V_DISPLAY + M0_V_FRONT + M0_V_SYNC),
    h_pol:  M0_H_POL,
    v_pol:  M0_V_POL
  };

  localparam timing_t T1 = '{
    h_last: COUNT_W'(M1_H_DISPLAY + M1_H_FRONT + M1_H_SYNC + M1_H_BACK - 1),
    h_disp: COUNT_W'(M1_H_DISPLAY),
    h_ss:   COUNT_W'(M1_H_DISPLAY + M1_H_FRONT),
    h_se:   COUNT_W'(M1_H_DISPLAY + M1_H_FRONT + M1_H_SYNC),
    v_last: COUNT_W'(M1_V_DISPLAY + M1_V_FRONT + M1_V_SYNC + M1_V_BACK - 1),
    v_disp: COUNT_W'(M1_V_DISPLAY),
    v_ss:   COUNT_W'(M1_V_DISPLAY + M1_V_FRONT),
    v_se:   COUNT_W'(M1_V_DISPLAY + M1_V_FRONT + M1_V_SYNC),
    h_pol:  M1_H_POL,
    v_pol:  M1_V_POL
  };

  function automatic timing_t timing_of(input mode_e m);
    return (m == MODE1) ? T1 : T0;
  endfunction

  logic [COUNT_W-1:0] h_q, h_d;
  logic [COUNT_W-1:0] v_q, v_d;
  mode_e              mode_q, mode_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic               col0_q, col0_d;
  logic               origin_q, origin_d;

  timing_t            cur_t;
  timing_t            nxt_t;
  logic               hs_act;
  logic               vs_act;

  always_comb begin
    cur_t  = timing_of(mode_q);
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;

    if (ce) begin
      if (h_q == cur_t.h_last) begin
        h_d = '0;
        if (v_q == cur_t.v_last) begin
          v_d    = '0;
          // Mode is sampled only on the last pixel of the frame, so the new
          // thresholds first apply at the origin and counters stay in range.
          mode_d = mode_e'(mode_sel);
        end else begin
          v_d = v_q + COUNT_W'(1);
        end
      end else begin
        h_d = h_q + COUNT_W'(1);
      end
    end

    // Decode from next-state counters and next mode so the registered
    // outputs line up with h_count/v_count in the same cycle.
    nxt_t    = timing_of(mode_d);
    hs_act   = (h_d >= nxt_t.h_ss) && (h_d < nxt_t.h_se);
    vs_act   = (v_d >= nxt_t.v_ss) && (v_d < nxt_t.v_se);
    hsync_d  = hs_act ? nxt_t.h_pol : ~nxt_t.h_pol;
    vsync_d  = vs_act ? nxt_t.v_pol : ~nxt_t.v_pol;
    de_d     = (h_d < nxt_t.h_disp) && (v_d < nxt_t.v_disp);
    col0_d   = (h_d == '0);
    origin_d = (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      mode_q   <= MODE0;
      hsync_q  <= ~M0_H_POL;
      vsync_q  <= ~M0_V_POL;
      de_q     <= 1'b1;
      col0_q   <= 1'b1;
      origin_q <= 1'b1;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      mode_q   <= mode_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      col0_q   <= col0_d;
      origin_q <= origin_d;
    end
  end

  assign mode           = mode_q;
  assign h_count        = h_q;
  assign v_count        = v_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign display_enable = de_q;
  // Gating with ce keeps the strobes to one enabled cycle even when the
  // counters sit at column 0 across several disabled cycles.
  assign line_start     = col0_q & ce;
  assign frame_start    = origin_q & ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen using a reduced raster so many frames
//   fit in a short run. The reference model tracks a linear pixel index within
//   the frame and derives h/v by division, sync/enable by range tests.
module tb_vga_timing_gen;

  localparam int unsigned CW = 6;

  // Mode 0: 25 x 17 raster, both syncs active-low.
  localparam int unsigned A_HD = 16, A_HF = 2, A_HS = 4, A_HB = 3;
  localparam int unsigned A_VD = 10, A_VF = 2, A_VS = 2, A_VB = 3;
  // Mode 1: 24 x 13 raster, both syncs active-high.
  localparam int unsigned B_HD = 12, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int unsigned B_VD = 8,  B_VF = 1, B_VS = 2, B_VB = 2;

  typedef struct packed {
    int hd, hf, hs, hb, vd, vf, vs, vb;
    bit hp, vp;
  } tm_t;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          mode;
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
  } obs_t;

  function automatic tm_t tm(input int m);
    tm_t t;
    if (m == 0) t = '{A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, 1'b0, 1'b0};
    else        t = '{B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, 1'b1, 1'b1};
    return t;
  endfunction

  logic          clk_25mhz;
  logic          reset;
  logic          ce;
  logic          mode_sel;
  logic          mode;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          display_enable;
  logic          line_start;
  logic          frame_start;

  vga_timing_gen #(
    .COUNT_W(CW),
    .M0_H_DISPLAY(A_HD), .M0_H_FRONT(A_HF), .M0_H_SYNC(A_HS), .M0_H_BACK(A_HB),
    .M0_V_DISPLAY(A_VD), .M0_V_FRONT(A_VF), .M0_V_SYNC(A_VS), .M0_V_BACK(A_VB),
    .M0_H_POL(1'b0), .M0_V_POL(1'b0),
    .M1_H_DISPLAY(B_HD), .M1_H_FRONT(B_HF), .M1_H_SYNC(B_HS), .M1_H_BACK(B_HB),
    .M1_V_DISPLAY(B_VD), .M1_V_FRONT(B_VF), .M1_V_SYNC(B_VS), .M1_V_BACK(B_VB),
    .M1_H_POL(1'b1), .M1_V_POL(1'b1)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .reset(reset),
    .ce(ce),
    .mode_sel(mode_sel),
    .mode(mode),
    .h_count(h_count),
    .v_count(v_count),
    .hsync(hsync),
    .vsync(vsync),
    .display_enable(display_enable),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  initial clk_25mhz = 1'b0;
  always #5 clk_25mhz = ~clk_25mhz;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state: linear index within the frame and active mode.
  int   pos   = 0;
  int   mmode = 0;

  task automatic model_step(input bit rst, input bit c, input bit msel);
    tm_t  t;
    int   ht, vt, h, v;
    obs_t e;
    t  = tm(mmode);
    ht = t.hd + t.hf + t.hs + t.hb;
    vt = t.vd + t.vf + t.vs + t.vb;
    if (rst) begin
      pos   = 0;
      mmode = 0;
    end else if (c) begin
      pos = pos + 1;
      if (pos == ht * vt) begin
        pos   = 0;
        mmode = msel ? 1 : 0;
      end
    end
    t  = tm(mmode);
    ht = t.hd + t.hf + t.hs + t.hb;
    h  = pos % ht;
    v  = pos / ht;
    e.h    = CW'(h);
    e.v    = CW'(v);
    e.mode = (mmode == 1);
    e.hs   = ((h >= t.hd + t.hf) && (h < t.hd + t.hf + t.hs)) ? t.hp : ~t.hp;
    e.vs   = ((v >= t.vd + t.vf) && (v < t.vd + t.vf + t.vs)) ? t.vp : ~t.vp;
    e.de   = (h < t.hd) && (v < t.vd);
    e.ls   = c && (h == 0);
    e.fs   = c && (pos == 0);
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge and hold through the next rising edge
  // and the sample point just after it.
  task automatic drive(input bit rst, input bit c, input bit msel);
    @(negedge clk_25mhz);
    reset    = rst;
    ce       = c;
    mode_sel = msel;
    model_step(rst, c, msel);
  endtask

  // Monitor: every cycle the DUT presents a raster sample; compare it with
  // the oldest expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk_25mhz);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.h    = h_count;
        a.v    = v_count;
        a.mode = mode;
        a.hs   = hsync;
        a.vs   = vsync;
        a.de   = display_enable;
        a.ls   = line_start;
        a.fs   = frame_start;
        cyc++;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL raster cyc%0d: got h=%0d v=%0d mode=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b, expected h=%0d v=%0d mode=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b",
                   cyc, a.h, a.v, a.mode, a.hs, a.vs, a.de, a.ls, a.fs,
                   e.h, e.v, e.mode, e.hs, e.vs, e.de, e.ls, e.fs);
        end
      end
    end
  end

  initial begin
    bit ms;
    reset    = 1'b1;
    ce       = 1'b0;
    mode_sel = 1'b0;

    // Reset, then two full mode-0 frames with ce held high.
    repeat (2) drive(1'b1, 1'b1, 1'b0);
    repeat (2 * 425) drive(1'b0, 1'b1, 1'b0);

    // mode_sel held high: switch at the end of the current frame.
    repeat (3 * 425) drive(1'b0, 1'b1, 1'b1);

    // Short mode_sel pulse that reverts before frame end: no switch.
    drive(1'b1, 1'b1, 1'b0);
    repeat (150) drive(1'b0, 1'b1, 1'b0);
    repeat (30)  drive(1'b0, 1'b1, 1'b1);
    repeat (400) drive(1'b0, 1'b1, 1'b0);

    // Enter mode 1, reset mid-frame, then continue.
    drive(1'b1, 1'b1, 1'b1);
    repeat (425 + 150) drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);

    // Randomised ce duty, occasional mode_sel toggles and rare resets.
    ms = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      bit r, c;
      r = ($urandom_range(0, 999) == 0);
      c = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 199) == 0) ms = ~ms;
      drive(r, c, ms);
    end

    @(posedge clk_25mhz);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, dual-mode VGA raster timing generator that replaces the fixed 640x480 controller. It produces the h/v pixel counters, sync pulses with per-mode polarity, display enable and line/frame start strobes. It supports a pixel clock-enable and a runtime mode switch that applies only on a frame boundary. It drives the pixel pipeline and the VGA output pins.

## Interface
Parameters:
- COUNT_W, 10, width of h_count/v_count; must hold every *_TOTAL-1.
- M0_H_DISPLAY / M0_H_FRONT / M0_H_SYNC / M0_H_BACK, 640/16/96/48, mode 0 horizontal timing in pixels.
- M0_V_DISPLAY / M0_V_FRONT / M0_V_SYNC / M0_V_BACK, 480/10/2/33, mode 0 vertical timing in lines.
- M0_H_POL / M0_V_POL, 0/0, mode 0 sync active level (0 = active-low).
- M1_H_* (four), 640/16/96/48, mode 1 horizontal timing.
- M1_V_* (four), 400/12/2/35, mode 1 vertical timing (640x400@70).
- M1_H_POL / M1_V_POL, 0/1, mode 1 sync active level.

Ports:
- clk_25mhz  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  pixel advance enable; all state holds when low.
- mode_sel  in  1  requested mode; sampled only at end of frame.
- mode  out  1  mode currently in effect.
- h_count  out  COUNT_W  horizontal position.
- v_count  out  COUNT_W  vertical position.
- hsync  out  1  horizontal sync, polarity per active mode.
- vsync  out  1  vertical sync, polarity per active mode.
- display_enable  out  1  high inside the visible area.
- line_start  out  1  high for one enabled cycle at h_count==0.
- frame_start  out  1  high for one enabled cycle at h_count==0, v_count==0.

## Operation
- H_TOTAL = DISPLAY+FRONT+SYNC+BACK per mode. Mode 0 is 800x525 and mode 1 is 800x449 with the defaults.
- Advance on ce=1:
  - h_count increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, v_count increments and wraps from V_TOTAL-1 to 0.
  - ce=0 freezes all registers.
- The active mode's parameters select every total and threshold. This is a mux of constants; there is no runtime arithmetic beyond compares.
- Horizontal sync is active for H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC. Vertical sync uses the same rule on v_count.
- Sync output = POL when active, ~POL otherwise.
- display_enable = (h_count < H_DISPLAY) && (v_count < V_DISPLAY).
- Mode switch:
  - mode_sel is sampled on the enabled cycle where (h_count, v_count) = (H_TOTAL-1, V_TOTAL-1) of the current mode.
  - The new mode applies from the next (0,0). `mode` changes on the same edge the counters wrap to (0,0).
  - mode_sel changes at any other time have no effect until the next frame end. A toggle that reverts before frame end is never seen.
- Counter bounds: v_count never exceeds V_TOTAL-1 of the mode in effect. Because switching occurs only at (0,0), no out-of-range state is reachable.

## Timing
- h_count, v_count and mode are registers. hsync, vsync and display_enable are registered and decoded from next-state counters, so they are aligned with h_count/v_count on the same cycle with zero skew.
- line_start and frame_start are the registered "at column 0" and "at origin" flags ANDed combinationally with ce. They therefore pulse exactly once per line or frame regardless of ce duty.
- Reset takes priority over ce and takes effect at the next edge. Values after reset:
  - h_count=0, v_count=0, mode=0.
  - display_enable=1.
  - hsync=~M0_H_POL, vsync=~M0_V_POL.
  - line_start=frame_start=ce.
- Reset mid-frame or mid-mode-switch unconditionally returns to mode 0 at origin. A pending sampled mode_sel is discarded.
- Latency from mode_sel to effect is the remainder of the current frame, at most one full frame of enabled cycles.

## Test plan
- Reset, ce=1 continuously, mode 0:
  - hsync is low for exactly h 656..751 on every line.
  - vsync is low for v 490..491.
  - display_enable count is 307200 per frame.
  - frame_start period is 420000 cycles.
- mode_sel=1 held from reset:
  - mode stays 0 until the first wrap, then becomes 1 at (0,0).
  - Next frame_start period is 359200.
  - vsync is high only for v 412..413; hsync stays active-low.
- ce toggled 1-0-1 pseudo-randomly:
  - Counters advance only on ce=1.
  - line_start asserts exactly once per line (800 enabled cycles).
  - No sync glitch while ce=0.
- mode_sel pulsed 1 for 100 cycles mid-frame, then returned to 0 before frame end -> mode remains 0.
- Assert reset at (h=700, v=300) in mode 1 -> next cycle reads (0,0), mode=0, hsync=1, vsync=1, display_enable=1.
- Wrap check: at (799, 524) with ce=1, the next edge gives (0,0), frame_start=1, line_start=1, display_enable=1.
